// File: rtl/rx_demux_if.sv
// Receive-side bundle of the multiplexed serial link: the incoming line plus
// the three demultiplexed channel outputs and status flags.
interface rx_demux_if #(
  parameter int BUFF_SIZE = 8
);
  logic                 rx;
  logic [BUFF_SIZE-1:0] data_out_ch_1;
  logic [BUFF_SIZE-1:0] data_out_ch_2;
  logic [BUFF_SIZE-1:0] data_out_ch_3;
  logic                 valid_ch_1;
  logic                 valid_ch_2;
  logic                 valid_ch_3;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  rx,
    output data_out_ch_1, data_out_ch_2, data_out_ch_3,
    output valid_ch_1, valid_ch_2, valid_ch_3,
    output parity_err, frame_err, busy
  );

  modport master (
    output rx,
    input  data_out_ch_1, data_out_ch_2, data_out_ch_3,
    input  valid_ch_1, valid_ch_2, valid_ch_3,
    input  parity_err, frame_err, busy
  );
endinterface

// File: rtl/rx_demux.sv
// Serial receiver for the three-channel multiplexed line: deserializes
// start/chan/data/parity/stop frames and routes good payloads by channel tag.
module rx_demux #(
  parameter int BUFF_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input logic       clk,
  input logic       rst,
  rx_demux_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(BUFF_SIZE + 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] CHAN_LAST = IW'(1);
  localparam logic [IW-1:0] DATA_LAST = IW'(BUFF_SIZE - 1);

  typedef enum logic [2:0] {IDLE, START, CHAN, DATA, PARITY, STOP} state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_s, armed;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [1:0]           chan_sr;
  logic [BUFF_SIZE-1:0] data_sr;
  logic [BUFF_SIZE:0]   data_shift;
  logic                 par_bit;
  logic                 tick, done;
  logic                 bad_frame, bad_par, good;
  logic [BUFF_SIZE-1:0] data_1, data_2, data_3;
  logic                 valid_1, valid_2, valid_3, perr_q, ferr_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // tick marks a mid-bit sample point; done marks the stop-bit sample
  always_comb begin
    state_n = state;
    tick    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:   if (armed && !rx_s) state_n = START;
      START:  if (cnt == HALF_M1) begin
                tick    = 1'b1;
                state_n = rx_s ? IDLE : CHAN;
              end
      CHAN:   if (cnt == FULL_M1) begin
                tick = 1'b1;
                if (idx == CHAN_LAST) state_n = DATA;
              end
      DATA:   if (cnt == FULL_M1) begin
                tick = 1'b1;
                if (idx == DATA_LAST) state_n = PARITY;
              end
      PARITY: if (cnt == FULL_M1) begin
                tick    = 1'b1;
                state_n = STOP;
              end
      STOP:   if (cnt == FULL_M1) begin
                tick    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
              end
      default: state_n = IDLE;
    endcase
  end

  // Framing problems take precedence over parity when a frame resolves
  assign bad_frame  = done && (!rx_s || (chan_sr == 2'b00));
  assign bad_par    = done && !bad_frame && ((^{chan_sr, data_sr}) != par_bit);
  assign good       = done && !bad_frame && !bad_par;
  assign data_shift = {rx_s, data_sr};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
      armed   <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
      chan_sr <= '0;
      data_sr <= '0;
      par_bit <= 1'b0;
      data_1  <= '0;
      data_2  <= '0;
      data_3  <= '0;
      valid_1 <= 1'b0;
      valid_2 <= 1'b0;
      valid_3 <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;

      // Re-arm only once the line is seen high, so a held-low break cannot restart
      if (state == IDLE && rx_s) armed <= 1'b1;
      else if (done)             armed <= 1'b0;

      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + 1'b1;

      if (state == IDLE || (tick && state_n != state)) idx <= '0;
      else if (tick)                                   idx <= idx + 1'b1;

      if (tick && state == CHAN)   chan_sr <= {rx_s, chan_sr[1]};
      if (tick && state == DATA)   data_sr <= data_shift[BUFF_SIZE:1];
      if (tick && state == PARITY) par_bit <= rx_s;

      valid_1 <= good && (chan_sr == 2'd1);
      valid_2 <= good && (chan_sr == 2'd2);
      valid_3 <= good && (chan_sr == 2'd3);
      perr_q  <= bad_par;
      ferr_q  <= bad_frame;

      if (good && chan_sr == 2'd1) data_1 <= data_sr;
      if (good && chan_sr == 2'd2) data_2 <= data_sr;
      if (good && chan_sr == 2'd3) data_3 <= data_sr;
    end
  end

  assign bus.data_out_ch_1 = data_1;
  assign bus.data_out_ch_2 = data_2;
  assign bus.data_out_ch_3 = data_3;
  assign bus.valid_ch_1    = valid_1;
  assign bus.valid_ch_2    = valid_2;
  assign bus.valid_ch_3    = valid_3;
  assign bus.parity_err    = perr_q;
  assign bus.frame_err     = ferr_q;
  assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_rx_demux.sv
// Self-checking bench for rx_demux: drives serial frames and compares every
// cycle against an event-level model of the expected strobes and registers.
module tb_rx_demux;

  localparam int B         = 8;
  localparam int CPB       = 16;
  localparam int PULSE_OFS = 3 + CPB / 2 + (B + 4) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rx_demux_if #(.BUFF_SIZE(B)) bus ();

  rx_demux #(.BUFF_SIZE(B), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 good, 1 parity error, 2 framing error
  typedef struct {
    int           start;
    int           at;
    int           kind;
    int           chan;
    logic [B-1:0] data;
  } ev_t;

  ev_t          evq[$];
  logic [B-1:0] expData [1:3];
  int           tests = 0;
  int           fails = 0;
  int           validSeen = 0;
  int           perrSeen = 0;
  int           ferrSeen = 0;
  int           busyHigh = 0;
  int           lastPulseCyc [1:3];
  logic         busyAtPulse = 1'b1;
  bit           watchBusy = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic parityOf(input logic [1:0] c, input logic [B-1:0] d);
    return ($countones({c, d}) % 2) == 1;
  endfunction

  // Per-cycle comparison against the event model
  always @(negedge clk) begin : compare
    logic [2:0] expV;
    logic       expPe, expFe, busyKnown, expBusy;
    ev_t        ev;
    if (rst) begin
      for (int k = 1; k <= 3; k++) expData[k] = '0;
      evq.delete();
    end else begin
      expV      = '0;
      expPe     = 1'b0;
      expFe     = 1'b0;
      busyKnown = 1'b0;
      expBusy   = 1'b0;
      if (evq.size() > 0) begin
        if (cyc >= evq[0].start + 3 && cyc < evq[0].at) begin
          busyKnown = 1'b1;
          expBusy   = 1'b1;
        end
        if (cyc == evq[0].at) begin
          ev        = evq.pop_front();
          busyKnown = 1'b1;
          expBusy   = 1'b0;
          case (ev.kind)
            0: begin
              expV[ev.chan-1]  = 1'b1;
              expData[ev.chan] = ev.data;
            end
            1: expPe = 1'b1;
            default: expFe = 1'b1;
          endcase
        end
      end
      checkOutput("cycle outputs {v3,v2,v1,perr,ferr,d1,d2,d3}",
                  32'({bus.valid_ch_3, bus.valid_ch_2, bus.valid_ch_1, bus.parity_err, bus.frame_err,
                       bus.data_out_ch_1, bus.data_out_ch_2, bus.data_out_ch_3}),
                  32'({expV, expPe, expFe, expData[1], expData[2], expData[3]}));
      if (busyKnown) checkOutput("busy in frame", 32'(bus.busy), 32'(expBusy));
      if (bus.valid_ch_1) begin validSeen++; lastPulseCyc[1] = cyc; busyAtPulse = bus.busy; end
      if (bus.valid_ch_2) begin validSeen++; lastPulseCyc[2] = cyc; busyAtPulse = bus.busy; end
      if (bus.valid_ch_3) begin validSeen++; lastPulseCyc[3] = cyc; busyAtPulse = bus.busy; end
      if (bus.parity_err) perrSeen++;
      if (bus.frame_err)  ferrSeen++;
      if (watchBusy && bus.busy) busyHigh++;
    end
  end

  task automatic applyStimulus(input logic level, input int cycles);
    bus.rx = level;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input int chan, input logic [B-1:0] data, input logic par, input logic stop);
    ev_t        e;
    logic [1:0] c;
    c       = chan[1:0];
    e.start = cyc;
    e.at    = cyc + PULSE_OFS;
    e.chan  = chan;
    e.data  = data;
    if (!stop || c == 2'd0)         e.kind = 2;
    else if (par != parityOf(c, data)) e.kind = 1;
    else                            e.kind = 0;
    evq.push_back(e);
    applyStimulus(1'b0, CPB);
    for (int i = 0; i < 2; i++) applyStimulus(c[i], CPB);
    for (int i = 0; i < B; i++) applyStimulus(data[i], CPB);
    applyStimulus(par, CPB);
    applyStimulus(stop, CPB);
  endtask

  initial begin : stimulus
    int           k0, v0, p0, f0, b0;
    logic [B-1:0] d;
    bus.rx = 1'b1;
    for (int k = 1; k <= 3; k++) lastPulseCyc[k] = -1;

    // Reset with idle line, then 100 idle cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset data_out_ch_1", 32'(bus.data_out_ch_1), 32'h0);
    checkOutput("reset data_out_ch_2", 32'(bus.data_out_ch_2), 32'h0);
    checkOutput("reset data_out_ch_3", 32'(bus.data_out_ch_3), 32'h0);
    checkOutput("reset strobes", 32'({bus.valid_ch_1, bus.valid_ch_2, bus.valid_ch_3,
                                       bus.parity_err, bus.frame_err}), 32'h0);
    checkOutput("reset busy", 32'(bus.busy), 32'h0);
    applyStimulus(1'b1, 100);
    checkOutput("idle pulses", 32'(validSeen + perrSeen + ferrSeen), 32'h0);
    checkOutput("idle busy", 32'(bus.busy), 32'h0);

    // Single good frame on channel 1
    k0 = cyc;
    sendFrame(1, 8'h01, 1'b0, 1'b1);
    checkOutput("single pulse offset", 32'(lastPulseCyc[1] - k0), 32'd203);
    checkOutput("single data_out_ch_1", 32'(bus.data_out_ch_1), 32'h01);
    checkOutput("single data_out_ch_2", 32'(bus.data_out_ch_2), 32'h0);
    checkOutput("single data_out_ch_3", 32'(bus.data_out_ch_3), 32'h0);
    checkOutput("single busy at pulse", 32'(busyAtPulse), 32'h0);
    checkOutput("single valid count", 32'(validSeen), 32'd1);

    // Back-to-back stream of 30 frames
    v0 = validSeen;
    for (int i = 0; i < 30; i++) begin
      d = B'(i + 1);
      sendFrame((i % 3) + 1, d, parityOf(2'((i % 3) + 1), d), 1'b1);
    end
    applyStimulus(1'b1, 20);
    checkOutput("stream valid count", 32'(validSeen - v0), 32'd30);
    checkOutput("stream data_out_ch_1", 32'(bus.data_out_ch_1), 32'h1C);
    checkOutput("stream data_out_ch_2", 32'(bus.data_out_ch_2), 32'h1D);
    checkOutput("stream data_out_ch_3", 32'(bus.data_out_ch_3), 32'h1E);
    checkOutput("stream errors", 32'(perrSeen + ferrSeen), 32'h0);

    // Parity error: correct bit for chan=2/data=0x05 is 1, so send 0
    v0 = validSeen;
    p0 = perrSeen;
    sendFrame(2, 8'h05, 1'b0, 1'b1);
    applyStimulus(1'b1, 20);
    checkOutput("parity err count", 32'(perrSeen - p0), 32'd1);
    checkOutput("parity no valid", 32'(validSeen - v0), 32'd0);
    checkOutput("parity data_out_ch_2 held", 32'(bus.data_out_ch_2), 32'h1D);

    // Framing error followed by a long break, then recovery
    f0 = ferrSeen;
    b0 = busyHigh;
    sendFrame(3, 8'hAA, parityOf(2'd3, 8'hAA), 1'b0);
    watchBusy = 1'b1;
    applyStimulus(1'b0, 500);
    watchBusy = 1'b0;
    checkOutput("break frame err count", 32'(ferrSeen - f0), 32'd1);
    checkOutput("break busy cycles", 32'(busyHigh - b0), 32'd0);
    checkOutput("break data_out_ch_3 held", 32'(bus.data_out_ch_3), 32'h1E);
    applyStimulus(1'b1, 20);
    sendFrame(3, 8'h55, parityOf(2'd3, 8'h55), 1'b1);
    applyStimulus(1'b1, 10);
    checkOutput("recovery data_out_ch_3", 32'(bus.data_out_ch_3), 32'h55);

    // Short glitch: busy for half a bit, no strobes
    v0 = validSeen + perrSeen + ferrSeen;
    b0 = busyHigh;
    watchBusy = 1'b1;
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 30);
    watchBusy = 1'b0;
    checkOutput("glitch busy cycles", 32'(busyHigh - b0), 32'(CPB / 2));
    checkOutput("glitch no pulses", 32'(validSeen + perrSeen + ferrSeen - v0), 32'd0);
    checkOutput("glitch busy cleared", 32'(bus.busy), 32'h0);

    // Reset in the middle of a channel-1 frame's data bits
    v0 = validSeen;
    applyStimulus(1'b0, CPB);
    applyStimulus(1'b1, CPB);
    applyStimulus(1'b0, CPB);
    applyStimulus(1'b1, CPB);
    applyStimulus(1'b1, CPB);
    applyStimulus(1'b0, CPB / 2);
    rst    = 1'b1;
    bus.rx = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midreset busy", 32'(bus.busy), 32'h0);
    checkOutput("midreset data_out_ch_3", 32'(bus.data_out_ch_3), 32'h0);
    applyStimulus(1'b1, 30);
    checkOutput("midreset no valid", 32'(validSeen - v0), 32'd0);
    sendFrame(1, 8'h3C, parityOf(2'd1, 8'h3C), 1'b1);
    applyStimulus(1'b1, 10);
    checkOutput("post-reset valid count", 32'(validSeen - v0), 32'd1);
    checkOutput("post-reset data_out_ch_1", 32'(bus.data_out_ch_1), 32'h3C);
    checkOutput("all expected events seen", 32'(evq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
